clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Multi-channel, runtime-programmable clock divider / strobe generator.
//  Each channel divides clk by a software-loaded integer and produces two outputs:
//   - a near-50% duty divided clock
//   - a one-cycle tick strobe per period
//  Divisor changes are glitch-free (applied only at a period boundary). A global
//  sync realigns all channels' phase. Sits between the system clock and
//  slow peripherals (UART baud, timers, LED scan) in the SoC top level.
// PARAMETERS
//  CHANNELS     2   number of independent divider channels (>=1)
//  WIDTH        16  divisor/counter width in bits; max divisor 2**WIDTH-1
//  DEFAULT_DIV  12  divisor active in every channel after reset (< 2**WIDTH)
// PORTS
//  clk       in   1               system clock
//  reset     in   1               asynchronous, active-high reset
//  en        in   CHANNELS        per-channel run enable
//  div_i     in   CHANNELS*WIDTH  new divisor; channel c in bits [c*WIDTH +: WIDTH]
//  div_load  in   CHANNELS        1-cycle strobe: capture div_i slice into pending reg
//  sync_i    in   1               1-cycle strobe: restart all enabled channels at cnt=0
//  clk_out   out  CHANNELS        divided clock, registered
//  tick      out  CHANNELS        1-cycle pulse on last count of each period, registered
//  pend      out  CHANNELS        1 = loaded divisor not yet applied
// BEHAVIOUR
//  Reset (async): cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV,
//   pend=0, clk_out=0, tick=0 for all channels.
//  Per channel (D = div_act, hi = (D+1)>>1), each posedge clk:
//   - en=0: cnt<=0, clk_out<=0, tick<=0 (counter cleared, not frozen)
//   - en=1, D>=1:
//       cnt <= (cnt==D-1) ? 0 : cnt+1
//       clk_out <= (cnt < hi)
//       tick <= (cnt == D-1)
//  Outputs lag cnt by one cycle; first clk_out rise is one cycle after en rises.
//  Duty: high hi cycles, low D-hi cycles.
//   - even D: exactly 50%
//   - odd D: high one cycle longer
//  D=1: clk_out held 1, tick high every cycle while en=1.
//  D=0: channel stopped (cnt<=0, clk_out<=0, tick<=0) regardless of en.
//  Divisor update:
//   - div_load=1: div_pend<=slice, pend<=1; a later load overwrites (last wins).
//   - apply point = wrap cycle (en=1, D>=1, cnt==D-1), or any cycle where en=0 or D=0.
//   - at the apply point with pend=1: div_act<=div_pend, pend<=0;
//     the new D governs from the cycle where cnt=0.
//   - div_load on an apply cycle: div_i slice goes straight to div_act, pend stays 0.
//   - the current period always completes with the old D; no runt or stretched pulse.
//  sync_i=1: every channel with en=1 gets cnt<=0 and pend applied immediately;
//   clk_out/tick registered from the pre-sync cnt that cycle. sync beats wrap.
//  Reset mid-operation: all state returns to reset values immediately (async);
//   div_act reverts to DEFAULT_DIV; a pending load is discarded.
//  Channels are fully independent except for the shared sync_i.
// STRUCTURE
//  Package clk_div_pkg:
//   - typedef logic [WIDTH-1:0] div_t (WIDTH given as a package parameter)
//   - localparams DIV_STOP=0, DIV_BYPASS=1
//  Sub-module clk_div_chan: one channel (cnt, div_act, div_pend, pend, outputs).
//   Top level is a generate loop of CHANNELS instances plus div_i slicing.
// TESTING
//  1 reset, en[0]=1, D=12 -> clk_out[0] period 12, 6 high/6 low; tick every 12th cycle.
//  2 D=5 loaded while en=0 -> applied at once (pend stays 0); then en=1 ->
//    clk_out 3 high/2 low; tick period 5.
//  3 D=4 running, load 6 at cnt=1 -> pend=1; remaining 4-cycle period completes;
//    next period 3 high/3 low; pend clears on the wrap cycle.
//  4 ch0 D=4, ch1 D=6, pulse sync_i -> both cnt=0 next cycle;
//    rising edges coincide every 12 cycles.
//  5 load D=0 -> channel stops after current period, outputs 0;
//    load D=1 -> clk_out=1 constant, tick=1 every cycle.
//  6 assert reset mid-period with pend=1 -> outputs 0 immediately;
//    after release D=12 (DEFAULT_DIV), pend=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_pkg : shared types and constants for the programmable divider |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package clk_div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef logic [DIV_WIDTH-1:0] div_t;

  // Divisor values with special meaning: 0 halts a channel, 1 passes clk-rate ticks.
  localparam int DIV_STOP   = 0;
  localparam int DIV_BYPASS = 1;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_chan : one divider channel with glitch-free divisor update   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             w_run;
  logic             w_wrap;
  logic             w_apply;
  logic [WIDTH:0]   w_hi;

  assign w_run   = en_i && (div_act_q != WIDTH'(DIV_STOP));
  assign w_wrap  = w_run && (cnt_q == div_act_q - WIDTH'(DIV_BYPASS));
  // A stopped or idle channel has no period in flight, so any cycle is a boundary.
  assign w_apply = !w_run || w_wrap || (sync_i && en_i);
  assign w_hi    = ({1'b0, div_act_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;

    if (!w_run) begin
      cnt_d = '0;
    end else begin
      clk_out_d = ({1'b0, cnt_q} < w_hi);
      tick_d    = w_wrap;
      cnt_d     = (w_wrap || sync_i) ? '0 : cnt_q + WIDTH'(1);
    end

    if (div_load_i) begin
      div_pend_d = div_i;
      if (w_apply) begin
        div_act_d = div_i;
        pend_d    = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (w_apply && pend_q) begin
      div_act_d = div_pend_q;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_act_q  <= WIDTH'(DEFAULT_DIV);
      div_pend_q <= WIDTH'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_prog : multi-channel runtime-programmable clock divider      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] div_i,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic                      sync_i,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pend
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en[c]),
      .div_i      (div_i[c*WIDTH +: WIDTH]),
      .div_load_i (div_load[c]),
      .sync_i     (sync_i),
      .clk_out_o  (clk_out[c]),
      .tick_o     (tick[c]),
      .pend_o     (pend[c])
    );
  end

endmodule : clk_div_prog
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clk_div_prog : randomized and directed bench for clk_div_prog     |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_clk_div_prog;

  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int DEF = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] div_i;
  logic [CH-1:0]   div_load;
  logic            sync_i;
  logic [CH-1:0]   clk_out, tick, pend;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: phase within the period, active divisor, queued divisor.
  int            m_ph[CH];
  int            m_d[CH];
  int            m_dp[CH];
  logic [CH-1:0] e_clk, e_tick, e_pend;

  always #5 clk = ~clk;

  clk_div_prog #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_i    (div_i),
    .div_load (div_load),
    .sync_i   (sync_i),
    .clk_out  (clk_out),
    .tick     (tick),
    .pend     (pend)
  );

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ph[c] = 0;
      m_d[c]  = DEF;
      m_dp[c] = DEF;
    end
    e_clk  = '0;
    e_tick = '0;
    e_pend = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int  d;
      int  nd;
      bit  active;
      bit  last;
      bit  boundary;
      d        = m_d[c];
      nd       = int'(div_i[c*W +: W]);
      active   = en[c] && (d > 0);
      last     = active && (m_ph[c] == d - 1);
      boundary = !active || last || (sync_i && en[c]);
      if (active) begin
        e_clk[c]  = (m_ph[c] < (d + 1) / 2);
        e_tick[c] = last;
        m_ph[c]   = (last || sync_i) ? 0 : m_ph[c] + 1;
      end else begin
        e_clk[c]  = 1'b0;
        e_tick[c] = 1'b0;
        m_ph[c]   = 0;
      end
      if (div_load[c]) begin
        m_dp[c] = nd;
        if (boundary) begin
          m_d[c]    = nd;
          e_pend[c] = 1'b0;
        end else begin
          e_pend[c] = 1'b1;
        end
      end else if (boundary && e_pend[c]) begin
        m_d[c]    = m_dp[c];
        e_pend[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load_ch(input int c, input int d);
    div_i[c*W +: W] = W'(d);
    div_load[c]     = 1'b1;
    step();
    div_load        = '0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({clk_out, tick, pend} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got clk=%b tick=%b pend=%b, want all 0", clk_out, tick, pend);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
  endtask

  task automatic test_default_div();
    int highs = 0;
    int ticks = 0;
    en[0] = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step();
      highs += int'(clk_out[0]);
      ticks += int'(tick[0]);
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL default_div cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    vectors++;
    if (highs != 18 || ticks != 3) begin
      miscompares++;
      $display("FAIL default_div_duty: got highs=%0d ticks=%0d want highs=18 ticks=3", highs, ticks);
    end
    en = '0;
    step();
  endtask

  task automatic test_load_idle();
    int highs = 0;
    int ticks = 0;
    load_ch(0, 5);
    vectors++;
    if (pend[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL load_idle_pend: got pend=%b want 0", pend[0]);
    end
    en[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i < 5) highs += int'(clk_out[0]);
      ticks += int'(tick[0]);
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL load_idle cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    vectors++;
    if (highs != 3 || ticks != 3) begin
      miscompares++;
      $display("FAIL load_idle_duty: got highs=%0d ticks=%0d want highs=3 ticks=3", highs, ticks);
    end
    en = '0;
    step();
  endtask

  task automatic test_midperiod_load();
    int highs = 0;
    load_ch(0, 4);
    en[0] = 1'b1;
    step();
    load_ch(0, 6);
    vectors++;
    if (pend[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midload_pend_set: got pend=%b want 1", pend[0]);
    end
    step();
    vectors++;
    if (pend[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_old_period: got pend=%b clk=%b want pend=1 clk=0", pend[0], clk_out[0]);
    end
    step();
    vectors++;
    if (pend[0] !== 1'b0 || tick[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midload_wrap: got pend=%b tick=%b want pend=0 tick=1", pend[0], tick[0]);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      highs += int'(clk_out[0]);
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL midload cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    vectors++;
    if (highs != 3 || tick[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midload_new_period: got highs=%0d tick=%b want highs=3 tick=1", highs, tick[0]);
    end
    en = '0;
    step();
  endtask

  task automatic test_sync();
    int            both = 0;
    logic [CH-1:0] prev;
    load_ch(0, 4);
    load_ch(1, 6);
    en = 2'b01;
    repeat ($urandom_range(5, 1)) step();
    en = 2'b11;
    repeat ($urandom_range(7, 1)) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    prev = clk_out;
    for (int i = 1; i <= 37; i++) begin
      step();
      if (i >= 2 && clk_out == 2'b11 && prev == 2'b00) both++;
      prev = clk_out;
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL sync cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    vectors++;
    if (both != 3) begin
      miscompares++;
      $display("FAIL sync_align: got %0d coincident rises want 3", both);
    end
    en = 2'b01;
  endtask

  task automatic test_stop_bypass();
    load_ch(0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL stop cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    vectors++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || pend[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_outputs: got clk=%b tick=%b pend=%b want 0/0/0", clk_out[0], tick[0], pend[0]);
    end
    load_ch(0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL bypass cyc %0d: got clk=%b tick=%b want 1/1", i, clk_out[0], tick[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    int ticks = 0;
    load_ch(0, 7);
    repeat (3) step();
    load_ch(0, 9);
    vectors++;
    if (pend[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pend_before: got pend=%b want 1", pend[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({clk_out, tick, pend} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got clk=%b tick=%b pend=%b want all 0", clk_out, tick, pend);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      highs += int'(clk_out[0]);
      ticks += int'(tick[0]);
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL rstmid cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    vectors++;
    if (highs != 12 || ticks != 2) begin
      miscompares++;
      $display("FAIL rstmid_default: got highs=%0d ticks=%0d want 12/2", highs, ticks);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) en = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        div_load[c] = ($urandom_range(9, 0) == 0);
        div_i[c*W +: W] = W'($urandom_range(9, 0));
      end
      sync_i = ($urandom_range(24, 0) == 0);
      step();
      vectors++;
      if ({clk_out, tick, pend} !== {e_clk, e_tick, e_pend}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b/%b/%b want %b/%b/%b", i, clk_out, tick, pend, e_clk, e_tick, e_pend);
      end
    end
    div_load = '0;
    sync_i   = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    en       = '0;
    div_i    = '0;
    div_load = '0;
    sync_i   = 1'b0;
    model_reset();
    test_reset();
    test_default_div();
    test_load_idle();
    test_midperiod_load();
    test_sync();
    test_stop_bypass();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_clk_div_prog
`default_nettype wire
